// File: rtl/voice_allocator_if.sv
// Key inputs and voice control outputs of the polyphony scheduler.
// master drives keys; slave is the allocator side.
interface voice_allocator_if #(
   parameter int NUM_KEYS   = 13,
   parameter int NUM_VOICES = 4,
   parameter int NW         = $clog2(NUM_KEYS)
);
   logic [NUM_KEYS-1:0]      keys;
   logic [NUM_VOICES-1:0]    voice_en;
   logic [NUM_VOICES-1:0]    voice_gate;
   logic [NUM_VOICES*NW-1:0] voice_note;
   logic                     steal_pulse;
   logic                     pending_any;

   modport master (
      output keys,
      input  voice_en, voice_gate, voice_note, steal_pulse, pending_any
   );

   modport slave (
      input  keys,
      output voice_en, voice_gate, voice_note, steal_pulse, pending_any
   );
endinterface

// File: rtl/voice_allocator.sv
// Polyphony scheduler: queues key presses, grants one voice per cycle (lowest key first),
// latency press->gate is 2 edges; when every voice is ACTIVE it steals one round-robin.
module voice_allocator #(
   parameter int NUM_KEYS       = 13,
   parameter int NUM_VOICES     = 4,
   parameter int RELEASE_CYCLES = 1024,
   parameter int NW             = $clog2(NUM_KEYS)
) (
   input  logic             clk,
   input  logic             rst,
   voice_allocator_if.slave io
);
   localparam int VW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CW  = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam int NK2 = 1 << NW;

   typedef enum logic [1:0] {V_IDLE, V_ACTIVE, V_RELEASE} vstate_e;

   logic [NUM_KEYS-1:0] key_q, pending_q, pending_d;
   logic [NUM_KEYS-1:0] press, rel, grant_oh;
   logic [NK2-1:0]      rel_ext;
   logic [VW-1:0]       steal_ptr_q, steal_ptr_d;
   logic                steal_pulse_q, steal_pulse_d;

   vstate_e             state_q [NUM_VOICES];
   vstate_e             state_d [NUM_VOICES];
   logic [NW-1:0]       note_q  [NUM_VOICES];
   logic [NW-1:0]       note_d  [NUM_VOICES];
   logic [CW-1:0]       cnt_q   [NUM_VOICES];
   logic [CW-1:0]       cnt_d   [NUM_VOICES];

   logic                grant_vld, key_found;
   logic [NW-1:0]       grant_key;
   logic [VW-1:0]       sel_v, retrig_v, idle_v, relv_v;
   logic                retrig_hit, idle_hit, relv_hit, steal;

   assign press    = io.keys & ~key_q;
   assign rel      = ~io.keys & key_q;
   assign rel_ext  = NK2'(rel);
   assign grant_oh = grant_vld ? (NUM_KEYS'(1) << grant_key) : '0;

   // Lowest pending key wins the single grant slot this cycle.
   always_comb begin
      grant_vld = |pending_q;
      grant_key = '0;
      key_found = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (pending_q[k] && !key_found) begin
            grant_key = NW'(k);
            key_found = 1'b1;
         end
      end
   end

   always_comb begin
      retrig_hit = 1'b0;
      idle_hit   = 1'b0;
      relv_hit   = 1'b0;
      retrig_v   = '0;
      idle_v     = '0;
      relv_v     = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (state_q[v] == V_RELEASE && note_q[v] == grant_key && !retrig_hit) begin
            retrig_v   = VW'(v);
            retrig_hit = 1'b1;
         end
         if (state_q[v] == V_IDLE && !idle_hit) begin
            idle_v   = VW'(v);
            idle_hit = 1'b1;
         end
         if (state_q[v] == V_RELEASE && !relv_hit) begin
            relv_v   = VW'(v);
            relv_hit = 1'b1;
         end
      end
      steal = 1'b0;
      if (retrig_hit)    sel_v = retrig_v;
      else if (idle_hit) sel_v = idle_v;
      else if (relv_hit) sel_v = relv_v;
      else begin
         sel_v = steal_ptr_q;
         steal = 1'b1;
      end
   end

   always_comb begin
      pending_d     = (pending_q | press) & ~rel & ~grant_oh;
      steal_pulse_d = grant_vld & steal;
      steal_ptr_d   = steal_ptr_q;
      if (grant_vld && steal) begin
         steal_ptr_d = (steal_ptr_q == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
         state_d[v] = state_q[v];
         note_d[v]  = note_q[v];
         cnt_d[v]   = cnt_q[v];
         case (state_q[v])
            V_ACTIVE: begin
               if (rel_ext[note_q[v]]) begin
                  state_d[v] = V_RELEASE;
                  cnt_d[v]   = CW'(RELEASE_CYCLES - 1);
               end
            end
            V_RELEASE: begin
               if (cnt_q[v] == '0) state_d[v] = V_IDLE;
               else                cnt_d[v]   = cnt_q[v] - 1'b1;
            end
            default: ;
         endcase
         // A grant overrides any release or expiry on the same voice.
         if (grant_vld && sel_v == VW'(v)) begin
            state_d[v] = V_ACTIVE;
            note_d[v]  = grant_key;
            cnt_d[v]   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q         <= '0;
         pending_q     <= '0;
         steal_ptr_q   <= '0;
         steal_pulse_q <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            state_q[v] <= V_IDLE;
            note_q[v]  <= '0;
            cnt_q[v]   <= '0;
         end
      end else begin
         key_q         <= io.keys;
         pending_q     <= pending_d;
         steal_ptr_q   <= steal_ptr_d;
         steal_pulse_q <= steal_pulse_d;
         for (int v = 0; v < NUM_VOICES; v++) begin
            state_q[v] <= state_d[v];
            note_q[v]  <= note_d[v];
            cnt_q[v]   <= cnt_d[v];
         end
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         io.voice_en[v]             = (state_q[v] != V_IDLE);
         io.voice_gate[v]           = (state_q[v] == V_ACTIVE);
         io.voice_note[v*NW +: NW]  = note_q[v];
      end
   end

   assign io.steal_pulse = steal_pulse_q;
   assign io.pending_any = |pending_q;
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler that shares a fixed pool of oscillator voices among a keyboard of note keys.
- Detects key press and release events, then queues presses and grants at most one voice per cycle.
- Drives per-voice enable, gate and note index. Each oscillator instance takes its enable from voice_en; envelope/mixing logic takes voice_gate.
- When all voices are busy it steals a voice round-robin.

Parameters:
NUM_KEYS, 13, number of key inputs (one octave plus top C); key index 0 = lowest note
NUM_VOICES, 4, number of oscillator voices managed
RELEASE_CYCLES, 1024, cycles a voice stays enabled after its key is released (release tail); must be >= 1
NW, $clog2(NUM_KEYS), width of one note index (4 at default)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
keys  in  NUM_KEYS  level key inputs, already synchronised and debounced, 1 = pressed
voice_en  out  NUM_VOICES  1 = voice oscillator running (ACTIVE or RELEASE)
voice_gate  out  NUM_VOICES  1 = voice key held (ACTIVE only)
voice_note  out  NUM_VOICES*NW  note index per voice, voice v in bits [v*NW +: NW]
steal_pulse  out  1  one-cycle pulse when an ACTIVE voice is reassigned
pending_any  out  1  1 = at least one press is queued and not yet granted

Behaviour:
- Reset (async, rst=1):
  - all voices IDLE; voice_en=0, voice_gate=0, voice_note=0
  - steal_pulse=0, pending_any=0
  - key_q=0, pending=0, steal_ptr=0, all release counters=0
- Edge detect: key_q is registered from keys every cycle.
  - press[k] = keys[k] & ~key_q[k]
  - rel[k] = ~keys[k] & key_q[k]
- Pending register, next value = (pending | press) & ~rel & ~grant. A key released before it is granted is silently dropped.
- Grant: each cycle, if pending != 0, select the lowest set index k and grant that key this cycle. At most one grant per cycle. Remaining presses wait; lower note index has priority.
- Voice selection for granted key k, in priority order:
  - a. a voice in RELEASE with note == k: retrigger it
  - b. the lowest-index IDLE voice
  - c. the lowest-index RELEASE voice
  - d. voice steal_ptr (all voices ACTIVE). steal_pulse=1 for the cycle following the grant edge; steal_ptr increments mod NUM_VOICES after each steal.
- Granted voice takes effect at the next edge: state ACTIVE, voice_note=k, release counter cleared.
- Latency: keys[k] rising before edge E0 sets pending at E0. With no competing pending keys, voice_gate/voice_en are high after E1 (2 edges).
- Per-voice state machine:
  - IDLE -> ACTIVE: on grant
  - ACTIVE -> RELEASE: when rel[voice_note] is seen; counter loads RELEASE_CYCLES-1, gate drops at the next edge, en stays 1
  - ACTIVE -> ACTIVE: on steal (note replaced)
  - RELEASE: counter decrements each cycle; at 0 with no grant -> IDLE (en drops); grant -> ACTIVE
  - IDLE holds the last voice_note value (no clear)
- Simultaneous events:
  - grant and release targeting the same voice in one cycle: grant wins
  - press and release of different keys in one cycle: both processed
  - a key re-pressed while its note is in RELEASE: retriggers the same voice (rule a), so no duplicate voice is allocated
- Two ACTIVE voices never hold the same note; a note's voice is always found by rule a before b-d.
- Release of a key whose voice was stolen has no effect on any voice.
- pending_any = |pending (registered value).
- rst asserted mid-operation returns everything to reset values immediately. A key held through reset deassertion is seen as a press on the first edge after reset (key_q=0) and is allocated normally.

Test Plan (NUM_VOICES=4, RELEASE_CYCLES=8):
- Press key 5 alone -> after 2 edges voice 0 en=1, gate=1, note=5; release key 5 -> gate low next edge, en low 8 edges later, note stays 5.
- Press keys 2, 7, 9 in the same cycle -> granted on 3 consecutive cycles to voices 0, 1, 2 with notes 2, 7, 9; pending_any high for exactly 3 cycles.
- Hold keys 0-3 (all voices ACTIVE), then press key 10 -> voice 0 note=10, steal_pulse for 1 cycle, steal_ptr=1; next press key 11 steals voice 1; releasing key 0 changes no voice.
- Release key 4 (voice 0 RELEASE, counter running), then press key 4 at release cycle 3 -> voice 0 returns to ACTIVE with note 4, no other voice enabled.
- Press key 6 and release it one cycle later, while 2 higher-priority keys are pending -> key 6 never granted, no voice gets note 6.
- Assert rst while 3 voices are ACTIVE and 2 keys are pending -> all outputs 0 at once; with keys still held, allocation restarts from voice 0 after rst falls.
